// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator TRNG controller: state encoding,
// default parameters and the counter-width helper.
package trng_pkg;

  localparam int NRO_DEF        = 8;
  localparam int WORD_W_DEF     = 32;
  localparam int SETTLE_DEF     = 16;
  localparam int SAMPLE_DIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/trng_sync2.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module trng_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // Two-stage capture of the asynchronous input vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      q      <= {W{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/trng_ro_ctrl.sv
// Ring-oscillator bank sequencer: release, settle, sample XOR of ROs, pack words,
// hand off over valid/ready. Define VON_NEUMANN_EN for pairwise debiasing.
module trng_ro_ctrl
  import trng_pkg::*;
#(
  parameter int NRO        = NRO_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              EN,
  input  logic [NRO-1:0]    RO_IN,
  output logic [NRO-1:0]    RO_RESET,
  output logic [WORD_W-1:0] DATA_O,
  output logic              VALID_O,
  input  logic              READY_I,
  output logic              BUSY_O
);

  localparam int SETTLE_CW = clog2_min1(SETTLE);
  localparam int DIV_CW    = clog2_min1(SAMPLE_DIV);
  localparam int BIT_CW    = clog2_min1(WORD_W);

  localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'(SETTLE - 1);
  localparam logic [DIV_CW-1:0]    DIV_LAST    = DIV_CW'(SAMPLE_DIV - 1);
  localparam logic [BIT_CW-1:0]    BIT_LAST    = BIT_CW'(WORD_W - 1);

  state_t                 state_r;
  logic [SETTLE_CW-1:0]   settle_cnt_r;
  logic [DIV_CW-1:0]      div_cnt_r;
  logic [BIT_CW-1:0]      bit_cnt_r;
  logic [WORD_W-2:0]      word_r;
  logic [NRO-1:0]         ro_sync_s;
  logic                   samp_bit_s;
  logic                   tick_s;
  logic                   emit_s;
  logic                   emit_bit_s;
  logic [WORD_W-1:0]      word_next_s;

  trng_sync2 #(.W(NRO)) u_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (RO_IN),
    .q     (ro_sync_s)
  );

`ifdef VON_NEUMANN_EN
  logic pair_a_r;
  logic pair_full_r;

  // First half of the debiasing pair; cleared whenever SAMPLE is not active.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pair_a_r    <= 1'b0;
      pair_full_r <= 1'b0;
    end else if (state_r != ST_SAMPLE) begin
      pair_a_r    <= 1'b0;
      pair_full_r <= 1'b0;
    end else if (tick_s) begin
      if (pair_full_r) begin
        pair_full_r <= 1'b0;
      end else begin
        pair_a_r    <= samp_bit_s;
        pair_full_r <= 1'b1;
      end
    end
  end
`endif

  // Sample tick decode and the bit (if any) produced by this tick.
  always_comb begin
    samp_bit_s = ^ro_sync_s;
    tick_s     = (state_r == ST_SAMPLE) && EN && (div_cnt_r == DIV_LAST);
`ifdef VON_NEUMANN_EN
    // 01 -> 0, 10 -> 1: the emitted bit equals the first of the pair.
    emit_s     = pair_full_r && (pair_a_r != samp_bit_s);
    emit_bit_s = pair_a_r;
`else
    emit_s     = 1'b1;
    emit_bit_s = samp_bit_s;
`endif
    word_next_s = {word_r, emit_bit_s};
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {SETTLE_CW{1'b0}};
      div_cnt_r    <= {DIV_CW{1'b0}};
      bit_cnt_r    <= {BIT_CW{1'b0}};
      word_r       <= {(WORD_W-1){1'b0}};
      RO_RESET     <= {NRO{1'b1}};
      DATA_O       <= {WORD_W{1'b0}};
      VALID_O      <= 1'b0;
      BUSY_O       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (EN) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= {SETTLE_CW{1'b0}};
            RO_RESET     <= {NRO{1'b0}};
            BUSY_O       <= 1'b1;
          end else begin
            RO_RESET <= {NRO{1'b1}};
            BUSY_O   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!EN) begin
            state_r  <= ST_IDLE;
            RO_RESET <= {NRO{1'b1}};
            BUSY_O   <= 1'b0;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            state_r   <= ST_SAMPLE;
            div_cnt_r <= {DIV_CW{1'b0}};
            bit_cnt_r <= {BIT_CW{1'b0}};
            word_r    <= {(WORD_W-1){1'b0}};
          end else begin
            settle_cnt_r <= settle_cnt_r + SETTLE_CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (!EN) begin
            state_r  <= ST_IDLE;
            RO_RESET <= {NRO{1'b1}};
            BUSY_O   <= 1'b0;
          end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_CW{1'b0}};
            if (emit_s) begin
              if (bit_cnt_r == BIT_LAST) begin
                DATA_O  <= word_next_s;
                VALID_O <= 1'b1;
                state_r <= ST_HOLD;
              end else begin
                word_r    <= word_next_s[WORD_W-2:0];
                bit_cnt_r <= bit_cnt_r + BIT_CW'(1);
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_CW'(1);
          end
        end
        ST_HOLD: begin
          // A pending word is always delivered, even if EN has dropped.
          if (VALID_O && READY_I) begin
            VALID_O <= 1'b0;
            if (EN) begin
              state_r   <= ST_SAMPLE;
              div_cnt_r <= {DIV_CW{1'b0}};
              bit_cnt_r <= {BIT_CW{1'b0}};
              word_r    <= {(WORD_W-1){1'b0}};
            end else begin
              state_r  <= ST_IDLE;
              RO_RESET <= {NRO{1'b1}};
              BUSY_O   <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          RO_RESET <= {NRO{1'b1}};
          VALID_O  <= 1'b0;
          BUSY_O   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_ro_ctrl.sv
// Directed bench for trng_ro_ctrl (NRO=8, WORD_W=8, SETTLE=16, SAMPLE_DIV=4).
// Edge 0 is the edge that samples EN=1; outputs are sampled 1 ns after each edge.
module tb_trng_ro_ctrl;

  logic       CLK;
  logic       RESET_N;
  logic       EN;
  logic [7:0] RO_IN;
  logic [7:0] RO_RESET;
  logic [7:0] DATA_O;
  logic       VALID_O;
  logic       READY_I;
  logic       BUSY_O;

  int checks;
  int errors;
  int vcnt;

  trng_ro_ctrl #(
    .NRO(8), .WORD_W(8), .SETTLE(16), .SAMPLE_DIV(4)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .EN       (EN),
    .RO_IN    (RO_IN),
    .RO_RESET (RO_RESET),
    .DATA_O   (DATA_O),
    .VALID_O  (VALID_O),
    .READY_I  (READY_I),
    .BUSY_O   (BUSY_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RO_IN[3] for edge t so that raw samples alternate 1,0,... in both words
  // (a sample on edge s sees RO_IN from edge s-2).
  function automatic logic [7:0] alt_pat(input int t);
    int j;
    logic [7:0] v;
    if (t < 15) return 8'h00;
    j = (t <= 48) ? (t - 15) / 4 : (t - 48) / 4;
    v = 8'h00;
    v[3] = (j % 2 == 0);
    return v;
  endfunction

  // Sample j (edge 20+4j) follows the sequence 1,1,0,1,1,0,0,0 repeating.
  function automatic logic [7:0] vn_pat(input int t);
    logic [7:0] seq;
    logic [7:0] v;
    int j;
    seq = 8'h1B;
    if (t < 15) return 8'h00;
    j = ((t - 15) / 4) % 8;
    v = 8'h00;
    v[3] = seq[j];
    return v;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    RESET_N = 1'b0;
    EN      = 1'b0;
    READY_I = 1'b0;
    RO_IN   = 8'h00;
    repeat (3) tick();
    chk("rst_ro_reset", RO_RESET, 8'hFF);
    chk("rst_valid",    VALID_O,  1'b0);
    chk("rst_data",     DATA_O,   8'h00);
    chk("rst_busy",     BUSY_O,   1'b0);
    RESET_N = 1'b1;
    repeat (20) tick();
    chk("idle_ro_reset", RO_RESET, 8'hFF);
    chk("idle_valid",    VALID_O,  1'b0);
    chk("idle_data",     DATA_O,   8'h00);
    chk("idle_busy",     BUSY_O,   1'b0);

`ifdef VON_NEUMANN_EN
    // Pairs per 8 samples: 11 none, 01->0, 10->1, 00 none; 8th bit at sample 29.
    vcnt = 0;
    for (int t = 0; t <= 136; t++) begin
      RO_IN = vn_pat(t);
      EN    = 1'b1;
      tick();
      if (VALID_O) vcnt++;
      if (t == 0) begin
        chk("vn_ro_release", RO_RESET, 8'h00);
        chk("vn_busy",       BUSY_O,   1'b1);
      end
      if (t == 135) chk("vn_valid_135", VALID_O, 1'b0);
      if (t == 136) begin
        chk("vn_valid_136", VALID_O, 1'b1);
        chk("vn_data",      DATA_O,  8'h55);
      end
    end
    chk("vn_valid_count", vcnt, 1);
`else
    // Constant entropy: XOR is 1 every sample, word 8'hFF at edge 48.
    RO_IN = 8'h01;
    EN    = 1'b1;
    vcnt  = 0;
    tick();
    chk("const_ro_release", RO_RESET, 8'h00);
    chk("const_busy",       BUSY_O,   1'b1);
    for (int t = 1; t <= 47; t++) begin
      tick();
      if (VALID_O) vcnt++;
    end
    chk("const_no_early_valid", vcnt, 0);
    tick();
    chk("const_valid_48", VALID_O, 1'b1);
    chk("const_data_48",  DATA_O,  8'hFF);
    vcnt = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (VALID_O && DATA_O == 8'hFF) vcnt++;
    end
    chk("const_hold_10", vcnt, 10);

    // EN drops during HOLD: word still delivered, IDLE on the handshake edge.
    EN = 1'b0;
    repeat (5) tick();
    chk("hold_en0_valid", VALID_O,  1'b1);
    chk("hold_en0_busy",  BUSY_O,   1'b1);
    chk("hold_en0_ro",    RO_RESET, 8'h00);
    READY_I = 1'b1;
    tick();
    chk("hs_valid", VALID_O,  1'b0);
    chk("hs_ro",    RO_RESET, 8'hFF);
    chk("hs_busy",  BUSY_O,   1'b0);
    chk("hs_data",  DATA_O,   8'hFF);

    // Alternating samples, READY held: words at edges 48 and 81 (handshake 49).
    vcnt = 0;
    for (int t = 0; t <= 82; t++) begin
      RO_IN = alt_pat(t);
      EN    = (t == 82) ? 1'b0 : 1'b1;
      tick();
      if (VALID_O) vcnt++;
      if (t == 48) begin
        chk("pat_valid_48", VALID_O, 1'b1);
        chk("pat_data_48",  DATA_O,  8'hAA);
      end
      if (t == 49) chk("pat_valid_49", VALID_O, 1'b0);
      if (t == 80) chk("pat_valid_80", VALID_O, 1'b0);
      if (t == 81) begin
        chk("pat_valid_81", VALID_O, 1'b1);
        chk("pat_data_81",  DATA_O,  8'hAA);
      end
      if (t == 82) begin
        chk("pat_idle_busy", BUSY_O,   1'b0);
        chk("pat_idle_ro",   RO_RESET, 8'hFF);
      end
    end
    chk("pat_valid_count", vcnt, 2);

    // Abort at edge 31, then a full 48-cycle run.
    READY_I = 1'b0;
    RO_IN   = 8'h01;
    vcnt    = 0;
    for (int t = 0; t <= 31; t++) begin
      EN = (t == 31) ? 1'b0 : 1'b1;
      tick();
      if (VALID_O) vcnt++;
    end
    chk("abort_busy",    BUSY_O,   1'b0);
    chk("abort_ro",      RO_RESET, 8'hFF);
    chk("abort_novalid", vcnt,     0);
    chk("abort_data",    DATA_O,   8'hAA);
    repeat (3) tick();
    EN = 1'b1;
    for (int t = 0; t <= 48; t++) begin
      tick();
      if (t == 47) chk("rerun_valid_47", VALID_O, 1'b0);
      if (t == 48) begin
        chk("rerun_valid_48", VALID_O, 1'b1);
        chk("rerun_data_48",  DATA_O,  8'hFF);
      end
    end
    EN      = 1'b0;
    READY_I = 1'b1;
    tick();
    chk("rerun_idle_busy",  BUSY_O,  1'b0);
    chk("rerun_idle_valid", VALID_O, 1'b0);
`endif

    // Reset mid-operation returns everything to reset values.
    EN      = 1'b1;
    READY_I = 1'b0;
    repeat (25) tick();
    RESET_N = 1'b0;
    #2;
    chk("midrst_ro",   RO_RESET, 8'hFF);
    chk("midrst_data", DATA_O,   8'h00);
    chk("midrst_busy", BUSY_O,   1'b0);
    RESET_N = 1'b1;
    EN      = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
